// File: rtl/calc_arbiter_seq.sv
// ---------------------------------------------------------------------------
// calc_arbiter_seq
//
// Purpose:
//   Round-robin arbiter and sequencer that shares one calculator datapath
//   (MUX1, 4-entry register file, ALU, MUX2) between two requesters. A
//   winning requester is granted, its ALU op is captured, and the datapath
//   controls are stepped through LOAD_A, LOAD_B, EXEC, OUT and ACK before
//   returning to IDLE.
//
// Optional feature:
//   CALC_FIXED_PRIO_EN - when defined, contention is resolved with fixed
//   priority (requester 0 always wins) and no round-robin pointer exists.
//   When undefined, contention alternates between the two requesters.
//
// Parameters:
//   OUT_HOLD - number of cycles the OUT state is held with done asserted
//              (legal 1..15).
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-low reset
//   req[1:0] level requests, bit i = requester i
//   op0/op1  ALU ops of requester 0/1, sampled at grant
//   gnt      one-hot grant (valid LOAD_A..ACK)
//   ack      one-cycle completion pulse to the granted requester
//   s1       MUX1 select (11 = A, 10 = B, 00 = ALU result, 01 = idle)
//   WA/WE    register-file write address / enable
//   RAA/REA  register-file read address / enable, port A
//   RAB/REB  register-file read address / enable, port B
//   C        ALU control
//   s2       MUX2 select (1 = drive result to output)
//   CS       current state code for the 7-segment display
//   done     result valid for the LED bar
// ---------------------------------------------------------------------------
module calc_arbiter_seq #(
    parameter int unsigned OUT_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic [1:0] s1,
    output logic [1:0] WA,
    output logic       WE,
    output logic [1:0] RAA,
    output logic       REA,
    output logic [1:0] RAB,
    output logic       REB,
    output logic [1:0] C,
    output logic       s2,
    output logic [3:0] CS,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        OUT    = 3'd4,
        ACK    = 3'd5
    } state_t;

    // The counter counts down to zero, so OUT lasts OUT_HOLD cycles.
    localparam logic [3:0] HOLD_INIT = 4'(OUT_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] gnt_q,   gnt_d;
    logic [1:0] op_q,    op_d;
    logic [3:0] cnt_q,   cnt_d;
`ifndef CALC_FIXED_PRIO_EN
    logic       last_q,  last_d;
`endif

    // State and capture registers. Reset parks the sequencer in IDLE with
    // the round-robin pointer on requester 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            op_q    <= 2'b00;
            cnt_q   <= 4'd0;
`ifndef CALC_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
`ifndef CALC_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state logic: arbitration happens only in IDLE, so request or op
    // changes during a transaction never disturb the captured grant and op.
    always_comb begin
        logic win;
        win     = 1'b0;
        state_d = state_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
`ifndef CALC_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b01) begin
                        win = 1'b0;
                    end else if (req == 2'b10) begin
                        win = 1'b1;
                    end else begin
`ifdef CALC_FIXED_PRIO_EN
                        win = 1'b0;
`else
                        win    = ~last_q;
                        last_d = ~last_q;
`endif
                    end
                    state_d = LOAD_A;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    op_d    = win ? op1 : op0;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: state_d = EXEC;
            EXEC: begin
                state_d = OUT;
                cnt_d   = HOLD_INIT;
            end
            OUT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Output decode depends only on registered state, so there is no
    // combinational path from req/op to any output.
    always_comb begin
        s1   = 2'b01;
        WA   = 2'b00;
        WE   = 1'b0;
        RAA  = 2'b00;
        REA  = 1'b0;
        RAB  = 2'b00;
        REB  = 1'b0;
        C    = 2'b00;
        s2   = 1'b0;
        done = 1'b0;
        ack  = 2'b00;
        gnt  = gnt_q;
        CS   = {1'b0, state_q};
        case (state_q)
            LOAD_A: begin
                s1 = 2'b11;
                WA = 2'b01;
                WE = 1'b1;
            end
            LOAD_B: begin
                s1 = 2'b10;
                WA = 2'b10;
                WE = 1'b1;
            end
            EXEC: begin
                s1  = 2'b00;
                WA  = 2'b11;
                WE  = 1'b1;
                RAA = 2'b01;
                REA = 1'b1;
                RAB = 2'b10;
                REB = 1'b1;
                C   = op_q;
            end
            OUT: begin
                RAA  = 2'b11;
                REA  = 1'b1;
                s2   = 1'b1;
                done = 1'b1;
            end
            ACK: begin
                ack = gnt_q;
                s2  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_calc_arbiter_seq.sv
// ---------------------------------------------------------------------------
// tb_calc_arbiter_seq
//
// Scoreboard bench for calc_arbiter_seq. Expected grant/op pairs are queued
// when a transaction is launched; a monitor pops one entry on every ack and
// compares the grant, captured ALU op, state trace and done duration seen
// during that transaction. A second instance with OUT_HOLD=3 covers the
// hold parameter.
// ---------------------------------------------------------------------------
module tb_calc_arbiter_seq;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] c;
    } exp_t;

    localparam logic [22:0] RESET_VEC = {4'd0, 2'b01, 17'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b11;
    logic [1:0] op0 = 2'b10;
    logic [1:0] op1 = 2'b01;
    logic [1:0] gnt, ack, s1, WA, RAA, RAB, C;
    logic       WE, REA, REB, s2, done;
    logic [3:0] CS;

    logic [1:0] req3 = 2'b00;
    logic [1:0] gnt3, ack3, s1_3, WA3, RAA3, RAB3, C3;
    logic       WE3, REA3, REB3, s2_3, done3;
    logic [3:0] CS3;

    logic [22:0] dutVec;

    int   vectors    = 0;
    int   miscompares = 0;
    int   ackCount   = 0;
    exp_t expQ[$];

    logic [1:0]  seenGnt;
    logic [1:0]  seenC;
    int          doneCnt;
    logic [19:0] csTrace;
    logic        prevAck;

    assign dutVec = {CS, s1, gnt, ack, WA, WE, RAA, REA, RAB, REB, C, s2, done};

    calc_arbiter_seq #(.OUT_HOLD(1)) dut (
        .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
        .gnt(gnt), .ack(ack), .s1(s1), .WA(WA), .WE(WE),
        .RAA(RAA), .REA(REA), .RAB(RAB), .REB(REB), .C(C),
        .s2(s2), .CS(CS), .done(done)
    );

    calc_arbiter_seq #(.OUT_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .op0(2'b01), .op1(2'b10),
        .gnt(gnt3), .ack(ack3), .s1(s1_3), .WA(WA3), .WE(WE3),
        .RAA(RAA3), .REA(REA3), .RAB(RAB3), .REB(REB3), .C(C3),
        .s2(s2_3), .CS(CS3), .done(done3)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives a request and waits (bounded) for nTrans acks; op1 is swapped
    // to o1Late once LOAD_A is visible, to show the captured op is stable.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] o0, input logic [1:0] o1,
                                 input logic [1:0] o1Late, input int nTrans);
        int target;
        bit changed;
        @(negedge clk); #1;
        target  = ackCount + nTrans;
        changed = 1'b0;
        req = r;
        op0 = o0;
        op1 = o1;
        for (int cyc = 0; cyc < 20 * nTrans; cyc++) begin
            @(negedge clk); #1;
            if (!changed && CS == 4'd1) begin
                op1     = o1Late;
                changed = 1'b1;
            end
            if (ackCount >= target) break;
        end
        req = 2'b00;
        if (ackCount < target) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ack_timeout: got %0d acks, expected %0d", ackCount, target);
        end
    endtask

    // Monitor: accumulates what the DUT shows during a transaction and
    // checks it against the head of the scoreboard when ack pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            seenGnt = 2'b00;
            seenC   = 2'b00;
            doneCnt = 0;
            csTrace = 20'd0;
            prevAck = 1'b0;
        end else begin
            if (prevAck) checkOutput("ack_one_cycle", {28'd0, ack, CS}, 32'd0);
            prevAck = 1'b0;
            if (CS != 4'd0) csTrace = {csTrace[15:0], CS};
            if (CS == 4'd1) seenGnt = gnt;
            if (CS == 4'd3) begin
                seenC = C;
                checkOutput("exec_ctrl", {21'd0, s1, WA, WE, RAA, REA, RAB, REB},
                            {21'd0, 2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1});
            end
            if (CS == 4'd4) begin
                if (done) doneCnt++;
                checkOutput("out_ctrl", {27'd0, RAA, REA, s2, done}, 32'h1f);
            end
            if (ack != 2'b00) begin
                ackCount++;
                prevAck = 1'b1;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", {30'd0, ack}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ack", {30'd0, ack}, {30'd0, e.gnt});
                    checkOutput("gnt", {30'd0, seenGnt}, {30'd0, e.gnt});
                    checkOutput("alu_ctrl", {30'd0, seenC}, {30'd0, e.c});
                    checkOutput("done_cycles", doneCnt, 1);
                    checkOutput("cs_trace", {12'd0, csTrace}, 32'h12345);
                    checkOutput("ack_state", {26'd0, CS, s2, done}, {26'd0, 4'd5, 1'b1, 1'b0});
                end
                seenGnt = 2'b00;
                seenC   = 2'b00;
                doneCnt = 0;
                csTrace = 20'd0;
            end
        end
    end

    // Directed test sequence.
    initial begin
        int  cnt3;
        bit  lastDone;
        bit  found;

        // Reset held with both requests pending: everything idle.
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {9'd0, dutVec}, {9'd0, RESET_VEC});
        checkOutput("reset_dut3_cs", {28'd0, CS3}, 32'd0);

        // Contention from reset: requester 0 first.
`ifdef CALC_FIXED_PRIO_EN
        expQ.push_back('{gnt: 2'b01, c: 2'b10});
        expQ.push_back('{gnt: 2'b01, c: 2'b10});
        expQ.push_back('{gnt: 2'b01, c: 2'b10});
`else
        expQ.push_back('{gnt: 2'b01, c: 2'b10});
        expQ.push_back('{gnt: 2'b10, c: 2'b01});
        expQ.push_back('{gnt: 2'b01, c: 2'b10});
`endif
        rst = 1'b1;
        applyStimulus(2'b11, 2'b10, 2'b01, 2'b01, 3);

        // Single request from requester 0.
        expQ.push_back('{gnt: 2'b01, c: 2'b10});
        applyStimulus(2'b01, 2'b10, 2'b00, 2'b00, 1);

        // Requester 1, op1 changed during LOAD_A must not reach C.
        expQ.push_back('{gnt: 2'b10, c: 2'b01});
        applyStimulus(2'b10, 2'b00, 2'b01, 2'b11, 1);

        // OUT_HOLD=3 instance: done for 3 cycles, ack right after.
        @(negedge clk); #1;
        req3     = 2'b01;
        cnt3     = 0;
        lastDone = 1'b0;
        found    = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk); #1;
            if (ack3 != 2'b00) begin
                found = 1'b1;
                break;
            end
            lastDone = done3 && (CS3 == 4'd4);
            if (done3 && CS3 == 4'd4) cnt3++;
        end
        req3 = 2'b00;
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL hold3_timeout: no ack within 40 cycles");
        end else begin
            checkOutput("hold3_done_cycles", cnt3, 3);
            checkOutput("hold3_ack_after_done", {31'd0, lastDone}, 32'd1);
            checkOutput("hold3_ack", {30'd0, ack3}, 32'd1);
        end

        // Reset in the middle of EXEC: outputs clear before the next edge.
        @(negedge clk); #1;
        req   = 2'b01;
        op0   = 2'b11;
        found = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk); #1;
            if (CS == 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL exec_timeout: EXEC never reached");
        end
        rst = 1'b0;
        #1;
        checkOutput("async_reset", {9'd0, dutVec}, {9'd0, RESET_VEC});
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fresh request after the abort restarts from LOAD_A.
        expQ.push_back('{gnt: 2'b01, c: 2'b01});
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_arbiter_seq.md
Name: calc_arbiter_seq

Overview:
- Round-robin arbiter and sequencer that shares the calculator datapath (MUX1, 4-entry register file, ALU, MUX2) between two requesters.
- Grants one requester, captures its op, and drives the register-file, ALU and mux controls through load-A, load-B, execute and output steps.
- Returns a one-cycle ack to the granted requester.
- Sits between the two front-end input ports and the datapath, replacing a single-user control unit at the top level.

Parameters:
OUT_HOLD, 1, cycles the OUT state is held with done asserted; legal 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  2  per-requester request, level; bit i = requester i
op0  input  2  ALU op of requester 0, sampled at grant
op1  input  2  ALU op of requester 1, sampled at grant
gnt  output 2  one-hot grant; top level steers the granted requester's operands into MUX1
ack  output 2  one-cycle completion pulse to the granted requester
s1   output 2  MUX1 select: 11 = operand A, 10 = operand B, 00 = ALU result, 01 = idle
WA   output 2  register-file write address
WE   output 1  write enable
RAA  output 2  read address A
REA  output 1  read enable A
RAB  output 2  read address B
REB  output 1  read enable B
C    output 2  ALU control
s2   output 1  MUX2 select (1 = drive result to output)
CS   output 4  current state code, for the 7-segment display
done output 1  result valid, for the LED bar

Behaviour:
- Reset (rst=0, async) forces all outputs to fixed values:
  - s1=01, CS=0.
  - gnt, ack, WA, WE, RAA, REA, RAB, REB, C, s2 and done all 0.
  - Internal captured op=00, hold counter=0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
- All outputs are registered or decoded from registered state only; no combinational path from req/op to outputs.
- States and CS codes: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, OUT=4, ACK=5.
- IDLE: idle output values.
  - If req != 00, next state is LOAD_A.
  - gnt is set one-hot to the winner and the winner's op is captured.
  - Winner when only one requester is asserted: that requester.
  - Winner when both are asserted: the requester != last; last is then updated to the winner.
- LOAD_A: s1=11, WA=01, WE=1, gnt held. Next state LOAD_B.
- LOAD_B: s1=10, WA=10, WE=1. Next state EXEC.
- EXEC: s1=00, WA=11, WE=1, RAA=01, REA=1, RAB=10, REB=1, C=captured op. Next state OUT; hold counter loads OUT_HOLD-1.
- OUT: RAA=11, REA=1, s2=1, done=1.
  - Counter decrements each cycle.
  - Leave to ACK when counter==0 (OUT lasts exactly OUT_HOLD cycles).
- ACK: ack[granted]=1 for exactly one cycle, s2=1, done=0. Next state IDLE with gnt cleared.
- Latency: grant to ack = 4 + OUT_HOLD cycles. With OUT_HOLD=1, IDLE to IDLE is 6 cycles.
- req is sampled only in IDLE.
  - Drops or rises in req during a transaction are ignored.
  - A requester still asserting req in IDLE after its ack is treated as a new request.
- A change on op0/op1 after grant does not affect C.
- Back-to-back: with both requesters held high, grants alternate 0,1,0,1 with one IDLE cycle between transactions.
- Reset asserted mid-transaction aborts immediately to IDLE with reset values. No ack is issued.

Optional Feature:
- CALC_FIXED_PRIO_EN defined:
  - Arbitration is fixed priority; requester 0 always wins contention.
  - last is neither kept nor updated.
- CALC_FIXED_PRIO_EN undefined: round-robin as described in Behaviour.

Test Plan:
1. Reset: hold rst=0, toggle clk with req=11 -> CS=0, s1=01, all other controls 0; release rst -> first grant gnt=01.
2. Single request: req=01, op0=10, OUT_HOLD=1 -> CS sequence 1,2,3,4,5,0.
   - EXEC shows s1=00, WA=11, WE=1, RAA=01, RAB=10, C=10.
   - ack=01 for one cycle at CS=5.
3. Contention: req=11 held for 3 transactions -> gnt sequence 01,10,01.
   - With CALC_FIXED_PRIO_EN: 01,01,01.
4. Op stability: req=10, op1=01, then change op1 to 11 during LOAD_A -> C=01 in EXEC.
5. Hold parameter: OUT_HOLD=3 -> done=1 for exactly 3 consecutive cycles with CS=4; ack one cycle later.
6. Mid-op reset: assert rst=0 during CS=3 -> outputs return to reset values asynchronously (before next clk edge), ack never pulses, next request restarts at LOAD_A.
